serdes_link_ctrl: RTL and testbench

Link-test sequencer for the PRBS → Gray → PAM4 → channel → DFE → PAM4 decode → Gray decode chain. It sequences the datapath: holds the datapath in reset, enables the PRBS, then runs a DFE training window. After that it measures bit error rate. Each received bit is compared against the transmitted bit, which is held in a reference FIFO. Error and bit counts are exported for display or CPU readout.

---
 rtl/serdes_ctrl_pkg.sv | 14 +
 rtl/ref_fifo.sv | 59 +++++
 rtl/serdes_link_ctrl.sv | 147 ++++++++++++++
 tb/tb_serdes_link_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_ctrl_pkg.sv
// Shared types for the SerDes link-test sequencer: FSM state encoding and width.
package serdes_ctrl_pkg;

  localparam int CTRL_STATE_W = 3;

  typedef enum logic [CTRL_STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DP_RST = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_MEAS   = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

endpackage

// File: rtl/ref_fifo.sv
// Single-clock 1-bit reference FIFO holding transmitted bits until their received
// copy arrives; a pop on empty with a simultaneous push returns the pushed bit.
module ref_fifo #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic pop_valid,
  output logic pop_bit,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             bypass;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign bypass    = push && pop && empty;
  assign do_pop    = pop && !empty;
  // A push on full is only accepted when a pop frees the slot in the same cycle.
  assign do_push   = push && !bypass && (!full || pop);
  assign pop_valid = do_pop || bypass;
  assign pop_bit   = empty ? push_bit : mem[rd_ptr];

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/serdes_link_ctrl.sv
// Link-test sequencer: holds the datapath in reset, runs PRBS with a DFE training
// window, then counts bit errors of received bits against a reference FIFO.
module serdes_link_ctrl
  import serdes_ctrl_pkg::*;
#(
  parameter int DP_RST_CYCLES = 16,
  parameter int TRAIN_BITS    = 1024,
  parameter int MEAS_BITS     = 65536,
  parameter int FIFO_DEPTH    = 64,
  parameter int CNT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    tx_bit,
  input  logic                    tx_bit_valid,
  input  logic                    rx_bit,
  input  logic                    rx_bit_valid,
  output logic                    dp_rst_n,
  output logic                    prbs_en,
  output logic                    train_en,
  output logic                    busy,
  output logic                    done,
  output logic                    fifo_err,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [CNT_W-1:0]        bit_cnt,
  output logic [CTRL_STATE_W-1:0] state
);

  localparam int DP_W = $clog2(DP_RST_CYCLES + 1);
  localparam int TR_W = $clog2(TRAIN_BITS + 1);

  ctrl_state_e     state_q;
  ctrl_state_e     state_d;
  logic [DP_W-1:0] dp_cnt_q;
  logic [TR_W-1:0] train_cnt_q;
  logic            start_run;
  logic            flush;
  logic            active;
  logic            push;
  logic            pop_req;
  logic            pop_valid;
  logic            pop_bit;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_fault;
  logic            measuring;

  assign active     = (state_q == ST_TRAIN) || (state_q == ST_MEAS);
  assign push       = active && tx_bit_valid;
  assign pop_req    = active && rx_bit_valid;
  assign fifo_fault = (push && fifo_full && !pop_req) || (pop_req && fifo_empty && !push);
  // An abort on the same edge as a pop leaves the counters untouched.
  assign measuring  = (state_q == ST_MEAS) && pop_valid && !abort;
  assign state      = state_q;

  ref_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_ref_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_bit  (tx_bit),
    .pop       (pop_req),
    .pop_valid (pop_valid),
    .pop_bit   (pop_bit),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    start_run = 1'b0;
    flush     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        flush = 1'b1;
        if (start) begin
          state_d   = ST_DP_RST;
          start_run = 1'b1;
        end
      end
      ST_DP_RST: begin
        flush = 1'b1;
        if (dp_cnt_q == DP_W'(DP_RST_CYCLES - 1)) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (pop_valid && train_cnt_q == TR_W'(TRAIN_BITS - 1)) state_d = ST_MEAS;
      end
      ST_MEAS: begin
        if (pop_valid && bit_cnt == CNT_W'(MEAS_BITS - 1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      start_run = 1'b0;
      flush     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dp_cnt_q    <= '0;
      train_cnt_q <= '0;
      dp_rst_n    <= 1'b1;
      prbs_en     <= 1'b0;
      train_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q  <= state_d;
      dp_rst_n <= (state_d != ST_DP_RST);
      prbs_en  <= (state_d == ST_TRAIN) || (state_d == ST_MEAS);
      train_en <= (state_d == ST_TRAIN);
      busy     <= (state_d == ST_DP_RST) || (state_d == ST_TRAIN) || (state_d == ST_MEAS);
      done     <= (state_d == ST_DONE);
      dp_cnt_q <= (state_q == ST_DP_RST) ? dp_cnt_q + DP_W'(1) : '0;
      if (state_q != ST_TRAIN)  train_cnt_q <= '0;
      else if (pop_valid)       train_cnt_q <= train_cnt_q + TR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      bit_cnt  <= '0;
      fifo_err <= 1'b0;
    end else if (start_run) begin
      err_cnt  <= '0;
      bit_cnt  <= '0;
      fifo_err <= 1'b0;
    end else begin
      if (fifo_fault && !abort) fifo_err <= 1'b1;
      if (measuring) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (rx_bit != pop_bit && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Bench for serdes_link_ctrl: tx looped to rx through a delay line, with a queue
// of transmitted bits as the reference model for the error/bit counters.
module tb_serdes_link_ctrl;

  localparam int DP    = 4;
  localparam int NTR   = 16;
  localparam int NMS   = 100;
  localparam int DLY   = 8;
  localparam int DLY2  = 10;

  logic        clk, rst;
  logic        start, abort, tx_bit, tx_bit_valid, rx_bit, rx_bit_valid;
  logic        dp_rst_n, prbs_en, train_en, busy, done, fifo_err;
  logic [31:0] err_cnt, bit_cnt;
  logic [2:0]  state;

  logic        ovf_start, ovf_abort, ovf_tx_b, ovf_tx_v, ovf_rx_b, ovf_rx_v;
  logic        ovf_dp_rst_n, ovf_prbs_en, ovf_train_en, ovf_busy, ovf_done, ovf_fifo_err;
  logic [31:0] ovf_err_cnt, ovf_bit_cnt;
  logic [2:0]  ovf_state;

  int n_vec, n_err;
  bit q[$];
  int m_pops, m_bit, m_err;
  bit m_run, mon_chk, tx_gate, force_rx, inj_en;
  logic [DLY-1:0]  dly_v, dly_b;
  logic [DLY2-1:0] ovf_dly_v, ovf_dly_b;

  serdes_link_ctrl #(
    .DP_RST_CYCLES(DP), .TRAIN_BITS(NTR), .MEAS_BITS(NMS), .FIFO_DEPTH(16), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid),
    .dp_rst_n(dp_rst_n), .prbs_en(prbs_en), .train_en(train_en), .busy(busy), .done(done),
    .fifo_err(fifo_err), .err_cnt(err_cnt), .bit_cnt(bit_cnt), .state(state)
  );

  serdes_link_ctrl #(
    .DP_RST_CYCLES(DP), .TRAIN_BITS(NTR), .MEAS_BITS(NMS), .FIFO_DEPTH(4), .CNT_W(32)
  ) dut_ovf (
    .clk(clk), .rst(rst), .start(ovf_start), .abort(ovf_abort),
    .tx_bit(ovf_tx_b), .tx_bit_valid(ovf_tx_v), .rx_bit(ovf_rx_b), .rx_bit_valid(ovf_rx_v),
    .dp_rst_n(ovf_dp_rst_n), .prbs_en(ovf_prbs_en), .train_en(ovf_train_en), .busy(ovf_busy),
    .done(ovf_done), .fifo_err(ovf_fifo_err), .err_cnt(ovf_err_cnt), .bit_cnt(ovf_bit_cnt),
    .state(ovf_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main datapath stand-in: consumes the edge just passed into the model, checks
  // the counters, then drives the next tx/rx values.
  initial begin
    bit exp_b;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        q.delete();
        m_pops = 0; m_bit = 0; m_err = 0; m_run = 1'b0;
        dly_v = '0; dly_b = '0;
        tx_bit_valid = 1'b0; tx_bit = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
      end else begin
        if (abort) begin
          q.delete();
          m_run = 1'b0;
        end else if (m_run) begin
          if (tx_bit_valid) q.push_back(tx_bit);
          if (rx_bit_valid && m_pops < NTR + NMS && q.size() > 0) begin
            exp_b = q.pop_front();
            m_pops++;
            if (m_pops > NTR) begin
              m_bit++;
              if (rx_bit != exp_b) m_err++;
            end
          end
        end
        if (mon_chk) begin
          n_vec++;
          if (bit_cnt !== 32'(m_bit) || err_cnt !== 32'(m_err)) begin
            n_err++;
            $display("FAIL counters: bit_cnt=%0d err_cnt=%0d, expected %0d/%0d", bit_cnt, err_cnt, m_bit, m_err);
          end
        end
        if (!dp_rst_n) begin
          dly_v = '0; dly_b = '0;
        end
        rx_bit_valid = dly_v[DLY-1] | force_rx;
        rx_bit       = force_rx ? 1'b0 : dly_b[DLY-1];
        if (inj_en && rx_bit_valid && (m_pops + 1 > NTR) && ((m_pops + 1 - NTR) inside {10, 50, 99}))
          rx_bit = ~rx_bit;
        tx_bit_valid = prbs_en & tx_gate;
        tx_bit       = 1'($urandom);
        dly_v = {dly_v[DLY-2:0], tx_bit_valid};
        dly_b = {dly_b[DLY-2:0], tx_bit};
      end
    end
  end

  // Overflow instance: 10-bit delay line against a 4-deep reference FIFO.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst || !ovf_dp_rst_n) begin
        ovf_dly_v = '0; ovf_dly_b = '0;
      end
      ovf_rx_v  = ovf_dly_v[DLY2-1];
      ovf_rx_b  = ovf_dly_b[DLY2-1];
      ovf_tx_v  = ovf_prbs_en;
      ovf_tx_b  = 1'($urandom);
      ovf_dly_v = {ovf_dly_v[DLY2-2:0], ovf_tx_v};
      ovf_dly_b = {ovf_dly_b[DLY2-2:0], ovf_tx_b};
    end
  end

  task automatic issue_start(input bit model_reset);
    @(negedge clk);
    start = 1'b1;
    if (model_reset) begin
      q.delete();
      m_pops = 0; m_bit = 0; m_err = 0; m_run = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_meas(input int min_bits, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (state == 3'd3 && m_bit >= min_bits) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (state !== 3'd0 || dp_rst_n !== 1'b1 || prbs_en !== 1'b0 || train_en !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || fifo_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: state=%0d dp_rst_n=%b prbs=%b train=%b busy=%b done=%b ferr=%b, expected 0/1/0/0/0/0/0",
               state, dp_rst_n, prbs_en, train_en, busy, done, fifo_err);
    end
    n_vec++;
    if (bit_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: bit_cnt=%0d err_cnt=%0d, expected 0/0", bit_cnt, err_cnt);
    end
    rst = 1'b0;
    mon_chk = 1'b1;
  endtask

  task automatic test_loopback();
    int lows;
    bit ok;
    issue_start(1'b1);
    lows = 0;
    for (int i = 0; i < 50 && !prbs_en; i++) begin
      if (!dp_rst_n) lows++;
      @(negedge clk);
    end
    n_vec++;
    if (lows != DP) begin
      n_err++;
      $display("FAIL dp_rst_len: low for %0d cycles, expected %0d", lows, DP);
    end
    n_vec++;
    if (prbs_en !== 1'b1 || train_en !== 1'b1 || dp_rst_n !== 1'b1 || busy !== 1'b1 || state !== 3'd2) begin
      n_err++;
      $display("FAIL train_entry: prbs=%b train=%b dp_rst_n=%b busy=%b state=%0d, expected 1/1/1/1/2",
               prbs_en, train_en, dp_rst_n, busy, state);
    end
    wait_done(2000, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL loopback_timeout: done=%b, expected 1", done);
    end
    n_vec++;
    if (bit_cnt !== 32'd100 || err_cnt !== 32'd0 || fifo_err !== 1'b0) begin
      n_err++;
      $display("FAIL loopback_result: bit=%0d err=%0d ferr=%b, expected 100/0/0", bit_cnt, err_cnt, fifo_err);
    end
    n_vec++;
    if (state !== 3'd4 || prbs_en !== 1'b0 || busy !== 1'b0 || train_en !== 1'b0) begin
      n_err++;
      $display("FAIL done_outputs: state=%0d prbs=%b busy=%b train=%b, expected 4/0/0/0", state, prbs_en, busy, train_en);
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (bit_cnt !== 32'd100 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: bit=%0d done=%b, expected 100/1", bit_cnt, done);
    end
  endtask

  task automatic test_error_injection();
    bit ok;
    inj_en = 1'b1;
    issue_start(1'b1);
    wait_done(2000, ok);
    n_vec++;
    if (!ok || err_cnt !== 32'd3 || bit_cnt !== 32'd100) begin
      n_err++;
      $display("FAIL error_inject: done=%b err=%0d bit=%0d, expected 1/3/100", done, err_cnt, bit_cnt);
    end
    inj_en = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_start_in_train();
    bit ok;
    issue_start(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (train_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (!ok || state !== 3'd2 || dp_rst_n !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_train: state=%0d dp_rst_n=%b busy=%b, expected 2/1/1", state, dp_rst_n, busy);
    end
  endtask

  task automatic test_underflow();
    bit ok;
    wait_meas(20, ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL meas_timeout: state=%0d, expected 3", state);
    end
    tx_gate = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++;
    if (fifo_err !== 1'b0) begin
      n_err++;
      $display("FAIL drain_clean: fifo_err=%b, expected 0", fifo_err);
    end
    force_rx = 1'b1;
    @(negedge clk);
    force_rx = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (fifo_err !== 1'b1 || bit_cnt !== 32'(m_bit) || state !== 3'd3) begin
      n_err++;
      $display("FAIL underflow: ferr=%b bit=%0d state=%0d, expected 1/%0d/3", fifo_err, bit_cnt, state, m_bit);
    end
  endtask

  task automatic test_abort();
    int held_bit, held_err;
    held_bit = m_bit;
    held_err = m_err;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (state !== 3'd0 || prbs_en !== 1'b0 || busy !== 1'b0 || dp_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL abort_state: state=%0d prbs=%b busy=%b dp_rst_n=%b, expected 0/0/0/1", state, prbs_en, busy, dp_rst_n);
    end
    n_vec++;
    if (bit_cnt !== 32'(held_bit) || err_cnt !== 32'(held_err) || fifo_err !== 1'b1) begin
      n_err++;
      $display("FAIL abort_hold: bit=%0d err=%0d ferr=%b, expected %0d/%0d/1", bit_cnt, err_cnt, fifo_err, held_bit, held_err);
    end
    tx_gate = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_start_abort_same();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (state !== 3'd0 || busy !== 1'b0 || dp_rst_n !== 1'b1 || fifo_err !== 1'b1 || bit_cnt !== 32'(m_bit)) begin
      n_err++;
      $display("FAIL start_abort: state=%0d busy=%b dp_rst_n=%b ferr=%b bit=%0d, expected 0/0/1/1/%0d",
               state, busy, dp_rst_n, fifo_err, bit_cnt, m_bit);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    issue_start(1'b1);
    wait_meas(5, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (!ok || state !== 3'd0 || bit_cnt !== 32'd0 || err_cnt !== 32'd0 || prbs_en !== 1'b0 ||
        dp_rst_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fifo_err !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: state=%0d bit=%0d err=%0d prbs=%b dp_rst_n=%b busy=%b done=%b ferr=%b, expected all reset",
               state, bit_cnt, err_cnt, prbs_en, dp_rst_n, busy, done, fifo_err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue_start(1'b1);
    wait_done(2000, ok);
    n_vec++;
    if (!ok || bit_cnt !== 32'd100 || err_cnt !== 32'd0 || fifo_err !== 1'b0) begin
      n_err++;
      $display("FAIL rerun_after_reset: done=%b bit=%0d err=%0d ferr=%b, expected 1/100/0/0", done, bit_cnt, err_cnt, fifo_err);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overflow();
    bit ok;
    @(negedge clk);
    ovf_start = 1'b1;
    @(negedge clk);
    ovf_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ovf_done) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok || ovf_fifo_err !== 1'b1 || ovf_bit_cnt !== 32'd100 || ovf_state !== 3'd4) begin
      n_err++;
      $display("FAIL overflow: done=%b ferr=%b bit=%0d state=%0d, expected 1/1/100/4",
               ovf_done, ovf_fifo_err, ovf_bit_cnt, ovf_state);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tx_bit = 1'b0; tx_bit_valid = 1'b0; rx_bit = 1'b0; rx_bit_valid = 1'b0;
    ovf_start = 1'b0; ovf_abort = 1'b0;
    ovf_tx_b = 1'b0; ovf_tx_v = 1'b0; ovf_rx_b = 1'b0; ovf_rx_v = 1'b0;
    mon_chk = 1'b0; tx_gate = 1'b1; force_rx = 1'b0; inj_en = 1'b0;
    test_reset();
    test_loopback();
    test_error_injection();
    test_start_in_train();
    test_underflow();
    test_abort();
    test_start_abort_same();
    test_reset_mid_run();
    test_overflow();
    mon_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
